cp_insert_param: RTL and testbench
==================================

# cp_insert_param

Parametrised cyclic-prefix inserter for the OFDM transmit chain, placed directly after the IFFT. It buffers each N-sample symbol in a two-bank (ping-pong) RAM and emits the last `cp_len` samples followed by the full symbol, so every output symbol is N+cp_len samples long. FFT size is set at build time; CP length is selectable at run time per symbol. Framing markers and back-pressure let it stream back-to-back symbols into the DAC/upconverter path.

## Interface
- `DW`, 20, bit width of each I and Q sample (signed).
- `LOG2_N`, 10, log2 of symbol length; N = 2^LOG2_N.
- `CP_MAX`, 256, largest legal CP length (must be ≤ N); `CW` = $clog2(CP_MAX+1).
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: reset, synchronous, active-low; all state is cleared on a clk edge with `rst`=0.
- `en` input 1: global clock enable; when 0, all registers (including RAM read register) hold.
- `in_valid` input 1: input sample valid.
- `in_sop` input 1: first sample of a symbol; qualified by `in_valid`.
- `in_i`, `in_q` input DW each: input sample, signed.
- `cp_len` input CW: CP length for the symbol, sampled on the accepted `in_sop` beat.
- `in_ready` output 1: write bank free; a beat is accepted when `in_valid & in_ready & en`.
- `out_valid` output 1: output sample valid.
- `out_sop` output 1: first output sample of a symbol (first CP sample, or first body sample if cp=0).
- `out_eop` output 1: last output sample of a symbol (sample N-1).
- `out_i`, `out_q` output DW each: output sample, signed.
- `err` output 1: one-cycle pulse on protocol error.

## Operation
- Storage: RAM of 2·N words × 2·DW bits, address {bank, index}; synchronous read, 1-cycle latency. Per-bank `full` flag and latched `cp` value.
- Write side: counter `wcnt` (LOG2_N bits), bank pointer `wbank`. `in_ready` = !full[wbank].
  - Accepted beat with `in_sop`: write at index 0, latch cp_len into cp[wbank], `wcnt`←1.
  - `in_sop` while `wcnt`≠0: abort partial symbol, restart at index 0 in same bank, pulse `err`.
  - Accepted beat without `in_sop` while `wcnt`=0 (no symbol open): discarded, pulse `err`.
  - Beat written at index N-1: set full[wbank], toggle `wbank`, `wcnt`←0.
  - cp_len > CP_MAX: latched value clamped to CP_MAX, pulse `err`.
- Read FSM, counter `rcnt`, bank pointer `rbank`:
  - IDLE: if full[rbank] → issue read; cp[rbank]>0: go CP with address N-cp; cp=0: go BODY with address 0.
  - CP: address increments; after address N-1 issued → BODY, next address 0.
  - BODY: address increments; after address N-1 issued → clear full[rbank], toggle `rbank`; if full of the new bank already set → straight into CP/BODY of next symbol with no gap, else IDLE.
- Read and write never target the same bank concurrently (full flag guards it); simultaneous set (write side) and clear (read side) of different banks' full flags both take effect.
- Output register stage: `out_valid`, `out_sop`, `out_eop` are the FSM's issue-cycle flags delayed by one cycle to align with RAM data.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_sop`=0, `out_eop`=0, `out_i`=`out_q`=0, `err`=0; FSM IDLE, both banks empty, `wbank`=`rbank`=0, counters 0.
- Latency: last input beat (index N-1) accepted at edge k → full visible after k → first read issued at edge k+1 → `out_valid`/`out_sop` high after edge k+2.
- Output is a contiguous burst of N+cp samples with `out_valid`=1; consecutive full banks produce gapless bursts.
- Sustained throughput requires input duty ≤ N/(N+cp); `in_ready` drops when both banks are full, rises the cycle after the read side clears a bank.
- `en`=0 freezes everything including outputs; behaviour resumes exactly where it stopped.
- `rst` low mid-symbol: partial writes and in-progress output abandoned; outputs at reset values next cycle.

## Test plan
- Defaults, cp_len=32, one symbol samples i=q=index 0..1023 → 1056 valid outputs: first=992 with `out_sop`, 992..1023, then 0..1023, `out_eop` on 1023; `out_sop` 2 cycles after last input.
- Three back-to-back symbols with cp_len 32, 0, 256 → bursts of 1056, 1024, 1280 samples, no gaps between bursts; cp=0 symbol has `out_sop` on sample 0.
- Continuous `in_valid`=1 for 4 symbols → `in_ready` drops while both banks full; no sample lost or duplicated; data matches model.
- `in_sop` at input index 500 → `err` pulse, symbol restarts; output contains only the restarted symbol.
- cp_len=300 → `err` pulse, CP of 256 samples emitted (first output = index 768).
- `en` toggled pseudo-randomly and `rst` asserted mid-burst → output sequence equals model with en-gated cycles removed; after reset all outputs 0 and `in_ready`=1.

Source files
------------

// File: rtl/cp_insert_param.sv
// rtl/cp_insert_param.sv - parametrised cyclic-prefix inserter with ping-pong symbol buffer
//
// Purpose:
//   Sits after the IFFT. Each N-sample input symbol is written into one bank of
//   a two-bank RAM. Once the bank is full, the read side emits the last cp
//   samples of the symbol (the cyclic prefix) and then the whole symbol. The
//   output symbol is therefore N+cp samples long. CP length is latched per
//   symbol on its start-of-symbol beat.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous active-low reset
//   en         global clock enable; every register holds while low
//   in_valid   input sample valid
//   in_sop     first sample of a symbol (qualified by in_valid)
//   in_i/in_q  input sample, signed DW bits each
//   cp_len     CP length for the symbol, sampled on the accepted in_sop beat
//   in_ready   current write bank is free
//   out_valid  output sample valid
//   out_sop    first output sample of a symbol
//   out_eop    last output sample of a symbol (body sample N-1)
//   out_i/out_q output sample, signed DW bits each
//   err        one-cycle pulse on a protocol error
module cp_insert_param #(
    parameter int DW     = 20,
    parameter int LOG2_N = 10,
    parameter int CP_MAX = 256,
    parameter int CW     = $clog2(CP_MAX + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 in_valid,
    input  logic                 in_sop,
    input  logic signed [DW-1:0] in_i,
    input  logic signed [DW-1:0] in_q,
    input  logic [CW-1:0]        cp_len,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic                 out_sop,
    output logic                 out_eop,
    output logic signed [DW-1:0] out_i,
    output logic signed [DW-1:0] out_q,
    output logic                 err
);

    localparam int N  = 1 << LOG2_N;
    localparam int AW = LOG2_N + 1;

    localparam logic [LOG2_N-1:0] LAST_IDX = {LOG2_N{1'b1}};
    localparam logic [LOG2_N-1:0] PENULT   = LAST_IDX - 1'b1;
    localparam logic [CW-1:0]     CP_MAX_C = CW'(CP_MAX);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CP   = 2'd1,
        S_BODY = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------
    logic [2*DW-1:0]   r_mem [0:2*N-1];

    logic [1:0]        r_full;
    logic [CW-1:0]     r_cp [0:1];

    logic              r_wbank;
    logic [LOG2_N-1:0] r_wcnt;
    logic              r_err;

    state_t            r_state;
    logic              r_rbank;
    logic [LOG2_N-1:0] r_rcnt;

    // Issue stage: address presented to the RAM plus the framing flags that
    // belong to it; the output stage delays the flags to line up with data.
    logic              r_iss_valid;
    logic              r_iss_sop;
    logic              r_iss_eop;
    logic [AW-1:0]     r_iss_addr;

    logic              r_out_valid;
    logic              r_out_sop;
    logic              r_out_eop;
    logic [2*DW-1:0]   r_rd_data;

    // ------------------------------------------------------------------
    // Write-side decode
    // ------------------------------------------------------------------
    logic              w_accept;
    logic              w_orphan;
    logic              w_sop_abort;
    logic              w_cp_over;
    logic [CW-1:0]     w_cp_latch;
    logic              w_wr_en;
    logic [LOG2_N-1:0] w_wr_idx;
    logic              w_wr_last;

    assign in_ready    = ~r_full[r_wbank];
    assign w_accept    = in_valid & in_ready & en;

    // A non-sop beat with no symbol open has nowhere to go and is dropped.
    assign w_orphan    = ~in_sop & (r_wcnt == '0);
    // An sop while a symbol is part-written throws the partial symbol away.
    assign w_sop_abort = in_sop & (r_wcnt != '0);
    assign w_cp_over   = cp_len > CP_MAX_C;
    assign w_cp_latch  = w_cp_over ? CP_MAX_C : cp_len;

    assign w_wr_en     = w_accept & ~w_orphan;
    assign w_wr_idx    = in_sop ? '0 : r_wcnt;
    assign w_wr_last   = w_wr_en & (w_wr_idx == LAST_IDX);

    // ------------------------------------------------------------------
    // Read-side decode
    // ------------------------------------------------------------------
    logic              w_rd_last;
    logic              w_start_bank;
    logic              w_start_ok;
    logic              w_start_now;
    logic [CW-1:0]     w_start_cp;
    logic [LOG2_N-1:0] w_start_idx;
    logic [LOG2_N-1:0] w_rcnt_inc;

    // Body sample N-1 was issued on the previous edge: this bank is done.
    assign w_rd_last    = (r_state == S_BODY) && (r_rcnt == LAST_IDX);

    // The next symbol comes from the other bank when finishing one,
    // otherwise from the current bank while idle.
    assign w_start_bank = w_rd_last ? ~r_rbank : r_rbank;
    assign w_start_ok   = r_full[w_start_bank];
    assign w_start_now  = w_start_ok && ((r_state == S_IDLE) || w_rd_last);
    assign w_start_cp   = r_cp[w_start_bank];

    // First CP address is N-cp; modulo-N arithmetic also maps cp=0 and cp=N to 0.
    assign w_start_idx  = LOG2_N'(0) - LOG2_N'(w_start_cp);
    assign w_rcnt_inc   = r_rcnt + 1'b1;

    // ------------------------------------------------------------------
    // Symbol RAM (write port; read port lives in the read FSM)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[{r_wbank, w_wr_idx}] <= {in_i, in_q};
        end
    end

    // ------------------------------------------------------------------
    // Write side and bank-full flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_full  <= '0;
            r_cp[0] <= '0;
            r_cp[1] <= '0;
            r_wbank <= 1'b0;
            r_wcnt  <= '0;
            r_err   <= 1'b0;
        end else if (en) begin
            r_err <= w_accept & (w_orphan | w_sop_abort | (in_sop & w_cp_over));

            if (w_accept && in_sop) begin
                r_cp[r_wbank] <= w_cp_latch;
            end

            if (w_wr_en) begin
                if (w_wr_idx == LAST_IDX) begin
                    r_wbank <= ~r_wbank;
                    r_wcnt  <= '0;
                end else begin
                    r_wcnt  <= w_wr_idx + 1'b1;
                end
            end

            // Set and clear always hit different banks, so both take effect.
            if (w_wr_last) begin
                r_full[r_wbank] <= 1'b1;
            end
            if (w_rd_last) begin
                r_full[r_rbank] <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read FSM, RAM read register and output stage
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_rbank     <= 1'b0;
            r_rcnt      <= '0;
            r_iss_valid <= 1'b0;
            r_iss_sop   <= 1'b0;
            r_iss_eop   <= 1'b0;
            r_iss_addr  <= '0;
            r_out_valid <= 1'b0;
            r_out_sop   <= 1'b0;
            r_out_eop   <= 1'b0;
            r_rd_data   <= '0;
        end else if (en) begin
            r_rd_data   <= r_mem[r_iss_addr];
            r_out_valid <= r_iss_valid;
            r_out_sop   <= r_iss_sop;
            r_out_eop   <= r_iss_eop;

            if (w_rd_last) begin
                r_rbank <= ~r_rbank;
            end

            if (w_start_now) begin
                r_iss_valid <= 1'b1;
                r_iss_sop   <= 1'b1;
                r_iss_eop   <= 1'b0;
                r_rcnt      <= w_start_idx;
                r_iss_addr  <= {w_start_bank, w_start_idx};
                r_state     <= (w_start_cp != '0) ? S_CP : S_BODY;
            end else if ((r_state == S_IDLE) || w_rd_last) begin
                r_iss_valid <= 1'b0;
                r_iss_sop   <= 1'b0;
                r_iss_eop   <= 1'b0;
                r_state     <= S_IDLE;
            end else if (r_state == S_CP) begin
                r_iss_valid <= 1'b1;
                r_iss_sop   <= 1'b0;
                r_iss_eop   <= 1'b0;
                if (r_rcnt == LAST_IDX) begin
                    // Prefix ended on sample N-1; the body restarts at 0.
                    r_rcnt     <= '0;
                    r_iss_addr <= {r_rbank, {LOG2_N{1'b0}}};
                    r_state    <= S_BODY;
                end else begin
                    r_rcnt     <= w_rcnt_inc;
                    r_iss_addr <= {r_rbank, w_rcnt_inc};
                end
            end else begin
                r_iss_valid <= 1'b1;
                r_iss_sop   <= 1'b0;
                r_iss_eop   <= (r_rcnt == PENULT);
                r_rcnt      <= w_rcnt_inc;
                r_iss_addr  <= {r_rbank, w_rcnt_inc};
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_sop   = r_out_sop;
    assign out_eop   = r_out_eop;
    assign out_i     = r_rd_data[2*DW-1:DW];
    assign out_q     = r_rd_data[DW-1:0];
    assign err       = r_err;

endmodule

// File: tb/tb_cp_insert_param.sv
// tb/tb_cp_insert_param.sv - scoreboard testbench for cp_insert_param
module tb_cp_insert_param;

    localparam int DW     = 20;
    localparam int LOG2_N = 10;
    localparam int CP_MAX = 256;
    localparam int CW     = $clog2(CP_MAX + 1);
    localparam int N      = 1 << LOG2_N;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 en = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_sop = 1'b0;
    logic signed [DW-1:0] in_i = '0;
    logic signed [DW-1:0] in_q = '0;
    logic [CW-1:0]        cp_len = '0;
    logic                 in_ready;
    logic                 out_valid;
    logic                 out_sop;
    logic                 out_eop;
    logic signed [DW-1:0] out_i;
    logic signed [DW-1:0] out_q;
    logic                 err;

    always #5 clk = ~clk;

    cp_insert_param #(.DW(DW), .LOG2_N(LOG2_N), .CP_MAX(CP_MAX)) dut (
        .clk(clk), .rst(rst), .en(en),
        .in_valid(in_valid), .in_sop(in_sop), .in_i(in_i), .in_q(in_q), .cp_len(cp_len),
        .in_ready(in_ready), .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
        .out_i(out_i), .out_q(out_q), .err(err)
    );

    int checks = 0;
    int errors = 0;

    // Scoreboard entries: {i, q, sop, eop}
    logic [2*DW+1:0] exp_q[$];
    // Reference model state: samples of the currently open input symbol
    logic [2*DW-1:0] m_sym[$];
    int              m_cp = 0;

    int exp_err = 0;
    int got_err = 0;
    int ecyc = 0;
    int last_acc = 0;
    int en_pct = 100;
    int sop_val = 0;
    bit saw_not_ready = 0;
    bit in_burst = 0;
    int sop_cyc[$];
    int eop_cyc[$];

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Behavioural model: collect a symbol; once N samples exist, the output is
    // samples [N-cp .. N-1] followed by [0 .. N-1].
    task automatic model_beat(input bit sop, input logic [2*DW-1:0] d, input int cp);
        bit e = 0;
        if (sop) begin
            if (m_sym.size() != 0) e = 1;
            if (cp > CP_MAX) begin
                e  = 1;
                cp = CP_MAX;
            end
            m_sym.delete();
            m_sym.push_back(d);
            m_cp = cp;
        end else if (m_sym.size() == 0) begin
            e = 1;
        end else begin
            m_sym.push_back(d);
        end
        if (e) exp_err++;
        if (m_sym.size() == N) begin
            for (int k = N - m_cp; k < N; k++)
                exp_q.push_back({m_sym[k], (k == N - m_cp), 1'b0});
            for (int k = 0; k < N; k++)
                exp_q.push_back({m_sym[k], (m_cp == 0 && k == 0), (k == N - 1)});
            m_sym.delete();
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge that was enabled.
    always @(posedge clk) begin : mon
        bit en_s, rst_s;
        logic [2*DW+1:0] got, e;
        en_s  = en;
        rst_s = rst;
        #1;
        if (!rst_s) begin
            in_burst = 0;
        end else if (en_s) begin
            ecyc++;
            if (err) got_err++;
            if (out_valid) begin
                got = {out_i, out_q, out_sop, out_eop};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL out_unexpected: got %h expected no output", got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        errors++;
                        $display("FAIL out_data: got %h expected %h at cycle %0d", got, e, ecyc);
                    end
                end
                if (out_sop) begin
                    in_burst = 1;
                    sop_val  = int'(out_i);
                    sop_cyc.push_back(ecyc);
                end
                if (out_eop) begin
                    in_burst = 0;
                    eop_cyc.push_back(ecyc);
                end
            end else if (in_burst) begin
                checks++;
                errors++;
                $display("FAIL burst_gap: got out_valid=0 expected 1 at cycle %0d", ecyc);
                in_burst = 0;
            end
        end
    end

    task automatic beat(input bit sop, input logic [2*DW-1:0] d, input int cp);
        bit done = 0;
        for (int t = 0; t < 20000 && !done; t++) begin
            @(negedge clk);
            en       = ($urandom_range(99) < en_pct);
            in_valid = 1'b1;
            in_sop   = sop;
            in_i     = d[2*DW-1:DW];
            in_q     = d[DW-1:0];
            cp_len   = CW'(cp);
            if (!in_ready) saw_not_ready = 1;
            if (en && in_ready) begin
                done     = 1;
                last_acc = ecyc + 1;
                model_beat(sop, d, cp);
            end
        end
        if (!done) chk("beat_timeout", 0, 1);
    endtask

    function automatic logic [2*DW-1:0] rnd_sample();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[2*DW-1:0];
    endfunction

    task automatic send_sym(input int cp, input bit ramp);
        logic [2*DW-1:0] d;
        for (int k = 0; k < N; k++) begin
            d = ramp ? {DW'(k), DW'(k)} : rnd_sample();
            beat(k == 0, d, cp);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_sop   = 1'b0;
            en       = ($urandom_range(99) < en_pct);
        end
    endtask

    task automatic drain(input string nm);
        int t = 0;
        while (exp_q.size() != 0 && t < 30000) begin
            idle(1);
            t++;
        end
        idle(6);
        chk(nm, exp_q.size(), 0);
    endtask

    task automatic do_reset(input string nm);
        @(negedge clk);
        rst      = 1'b0;
        en       = 1'b1;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        @(negedge clk);
        exp_q.delete();
        m_sym.delete();
        chk({nm, "_in_ready"}, in_ready, 1);
        chk({nm, "_out_valid"}, out_valid, 0);
        chk({nm, "_out_sop"}, out_sop, 0);
        chk({nm, "_out_eop"}, out_eop, 0);
        chk({nm, "_out_i"}, out_i, 0);
        chk({nm, "_out_q"}, out_q, 0);
        chk({nm, "_err"}, err, 0);
        rst = 1'b1;
    endtask

    initial begin
        int g0;
        int t;

        do_reset("rst0");

        // One ramp symbol, cp=32
        en_pct = 100;
        sop_cyc.delete();
        eop_cyc.delete();
        send_sym(32, 1);
        drain("t1_drain");
        chk("t1_sop_latency", (sop_cyc.size() > 0) ? sop_cyc[0] : -1, last_acc + 2);
        chk("t1_first_sample", sop_val, 992);
        chk("t1_burst_len", (eop_cyc.size() > 0 && sop_cyc.size() > 0) ? eop_cyc[0] - sop_cyc[0] + 1 : -1, N + 32);

        // Back-to-back symbols with cp 32, 0, 256
        sop_cyc.delete();
        eop_cyc.delete();
        send_sym(32, 0);
        send_sym(0, 0);
        send_sym(256, 0);
        drain("t2_drain");
        chk("t2_bursts", sop_cyc.size(), 3);
        chk("t2_no_gap", (sop_cyc.size() >= 2 && eop_cyc.size() >= 1) ? sop_cyc[1] - eop_cyc[0] : -1, 1);
        chk("t2_len_cp0", (sop_cyc.size() >= 2 && eop_cyc.size() >= 2) ? eop_cyc[1] - sop_cyc[1] + 1 : -1, N);
        chk("t2_len_cp256", (sop_cyc.size() >= 3 && eop_cyc.size() >= 3) ? eop_cyc[2] - sop_cyc[2] + 1 : -1, N + 256);

        // Continuous input, 4 symbols: back-pressure must appear
        saw_not_ready = 0;
        for (int s = 0; s < 4; s++) send_sym($urandom_range(16, CP_MAX), 0);
        drain("t3_drain");
        chk("t3_ready_dropped", saw_not_ready, 1);

        // Orphan beat, then an sop at index 500 restarting the symbol
        g0 = got_err;
        beat(1'b0, rnd_sample(), 0);
        for (int k = 0; k < 500; k++) beat(k == 0, rnd_sample(), 64);
        send_sym(64, 1);
        drain("t4_drain");
        chk("t4_err_pulses", got_err - g0, 2);
        chk("t4_first_sample", sop_val, N - 64);

        // Oversized CP is clamped
        g0 = got_err;
        send_sym(300, 1);
        drain("t5_drain");
        chk("t5_err_pulses", got_err - g0, 1);
        chk("t5_first_sample", sop_val, N - CP_MAX);

        // Random clock-enable with random CP lengths
        en_pct = 70;
        for (int s = 0; s < 3; s++) send_sym($urandom_range(0, 300), 0);
        drain("t6_drain");
        chk("t6_err_count", got_err, exp_err);

        // Reset in the middle of an output burst
        en_pct = 100;
        send_sym(100, 0);
        t = 0;
        while (!out_valid && t < 3000) begin
            idle(1);
            t++;
        end
        chk("t7_burst_started", out_valid, 1);
        idle(200);
        do_reset("t7_rst");
        en_pct = 70;
        send_sym(16, 1);
        drain("t7_drain");
        chk("t7_first_sample", sop_val, N - 16);
        chk("err_total", got_err, exp_err);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
